// File: rtl/emissor_talao.sv
// ---------------------------------------------------------------------------
// emissor_talao
//   Receipt emitter. On a request it captures the totaliser's price, weight
//   and tax values, converts all three to BCD in parallel (shift-add-3, one
//   bit per clock), then streams a fixed-width ASCII line to the printer:
//       'T' dddd 'P' dddd 'X' dd LF
//   using a valid/ready handshake.
//
// Ports
//   clk            in   clock, rising-edge active
//   rst            in   asynchronous reset, active high
//   emissao_talao  in   receipt-issue request (sampled only when idle)
//   soma_final     in   [11:0] unsigned total price
//   soma_peso      in   [11:0] unsigned total weight
//   valor_taxa     in   [4:0]  unsigned tax value
//   car_pronto     in   printer ready for a character
//   car_dado       out  [7:0] ASCII character (0x00 when not valid)
//   car_valido     out  car_dado is valid
//   ocupado        out  receipt in progress
//   talao_fim      out  one-cycle pulse when a receipt is complete
// ---------------------------------------------------------------------------
module emissor_talao (
    input  logic        clk,
    input  logic        rst,
    input  logic        emissao_talao,
    input  logic [11:0] soma_final,
    input  logic [11:0] soma_peso,
    input  logic [4:0]  valor_taxa,
    input  logic        car_pronto,
    output logic [7:0]  car_dado,
    output logic        car_valido,
    output logic        ocupado,
    output logic        talao_fim
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        ENVIA,
        FIM
    } state_t;

    state_t      r_state;
    state_t      w_next;

    // Binary operands double as the capture latches: they are loaded on the
    // capture edge and shifted out MSB-first into the BCD accumulators.
    logic [11:0] r_bin_f;
    logic [11:0] r_bin_p;
    logic [11:0] r_bin_t;
    logic [15:0] r_bcd_f;
    logic [15:0] r_bcd_p;
    logic [7:0]  r_bcd_t;
    logic [3:0]  r_cnt;
    logic [3:0]  r_idx;

    logic [15:0] w_step_f;
    logic [15:0] w_step_p;
    logic [7:0]  w_step_t;
    logic        w_last_bit;
    logic        w_last_char;
    logic [7:0]  w_char;

    // One double-dabble step on four digits: add 3 to every digit >= 5,
    // then shift left bringing in the next binary bit.
    function automatic logic [15:0] dabble4(input logic [15:0] b, input logic in_bit);
        logic [15:0] a;
        a = b;
        for (int unsigned d = 0; d < 4; d++) begin
            if (a[d*4 +: 4] >= 4'd5)
                a[d*4 +: 4] = a[d*4 +: 4] + 4'd3;
        end
        return (a << 1) | {15'b0, in_bit};
    endfunction

    // Two-digit variant for the tax value (max 31).
    function automatic logic [7:0] dabble2(input logic [7:0] b, input logic in_bit);
        logic [7:0] a;
        a = b;
        for (int unsigned d = 0; d < 2; d++) begin
            if (a[d*4 +: 4] >= 4'd5)
                a[d*4 +: 4] = a[d*4 +: 4] + 4'd3;
        end
        return (a << 1) | {7'b0, in_bit};
    endfunction

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return {4'h3, d};
    endfunction

    assign w_step_f    = dabble4(r_bcd_f, r_bin_f[11]);
    assign w_step_p    = dabble4(r_bcd_p, r_bin_p[11]);
    assign w_step_t    = dabble2(r_bcd_t, r_bin_t[11]);
    assign w_last_bit  = (r_cnt == 4'd11);
    assign w_last_char = (r_idx == 4'd13);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (emissao_talao)              w_next = CONV;
            CONV:    if (w_last_bit)                 w_next = ENVIA;
            ENVIA:   if (car_pronto && w_last_char)  w_next = FIM;
            FIM:                                     w_next = IDLE;
            default:                                 w_next = IDLE;
        endcase
    end

    // Datapath: capture, conversion and character index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin_f <= '0;
            r_bin_p <= '0;
            r_bin_t <= '0;
            r_bcd_f <= '0;
            r_bcd_p <= '0;
            r_bcd_t <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (emissao_talao) begin
                        r_bin_f <= soma_final;
                        r_bin_p <= soma_peso;
                        r_bin_t <= {7'b0, valor_taxa};
                        r_bcd_f <= '0;
                        r_bcd_p <= '0;
                        r_bcd_t <= '0;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end
                end
                CONV: begin
                    r_bcd_f <= w_step_f;
                    r_bcd_p <= w_step_p;
                    r_bcd_t <= w_step_t;
                    r_bin_f <= {r_bin_f[10:0], 1'b0};
                    r_bin_p <= {r_bin_p[10:0], 1'b0};
                    r_bin_t <= {r_bin_t[10:0], 1'b0};
                    r_cnt   <= r_cnt + 4'd1;
                    if (w_last_bit)
                        r_idx <= '0;
                end
                ENVIA: begin
                    if (car_pronto)
                        r_idx <= r_idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Character selection by index
    always_comb begin
        w_char = '0;
        case (r_idx)
            4'd0:    w_char = 8'h54;
            4'd1:    w_char = ascii_digit(r_bcd_f[15:12]);
            4'd2:    w_char = ascii_digit(r_bcd_f[11:8]);
            4'd3:    w_char = ascii_digit(r_bcd_f[7:4]);
            4'd4:    w_char = ascii_digit(r_bcd_f[3:0]);
            4'd5:    w_char = 8'h50;
            4'd6:    w_char = ascii_digit(r_bcd_p[15:12]);
            4'd7:    w_char = ascii_digit(r_bcd_p[11:8]);
            4'd8:    w_char = ascii_digit(r_bcd_p[7:4]);
            4'd9:    w_char = ascii_digit(r_bcd_p[3:0]);
            4'd10:   w_char = 8'h58;
            4'd11:   w_char = ascii_digit(r_bcd_t[7:4]);
            4'd12:   w_char = ascii_digit(r_bcd_t[3:0]);
            4'd13:   w_char = 8'h0A;
            default: w_char = '0;
        endcase
    end

    // Outputs are decoded from the state so reset clears them immediately.
    always_comb begin
        car_dado   = '0;
        car_valido = 1'b0;
        ocupado    = 1'b0;
        talao_fim  = 1'b0;
        case (r_state)
            CONV: begin
                ocupado = 1'b1;
            end
            ENVIA: begin
                ocupado    = 1'b1;
                car_valido = 1'b1;
                car_dado   = w_char;
            end
            FIM: begin
                ocupado   = 1'b1;
                talao_fim = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_emissor_talao.sv
module tb_emissor_talao;

    logic        clk;
    logic        rst;
    logic        emissao_talao;
    logic [11:0] soma_final;
    logic [11:0] soma_peso;
    logic [4:0]  valor_taxa;
    logic        car_pronto;
    logic [7:0]  car_dado;
    logic        car_valido;
    logic        ocupado;
    logic        talao_fim;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_chars [14];

    emissor_talao dut (
        .clk           (clk),
        .rst           (rst),
        .emissao_talao (emissao_talao),
        .soma_final    (soma_final),
        .soma_peso     (soma_peso),
        .valor_taxa    (valor_taxa),
        .car_pronto    (car_pronto),
        .car_dado      (car_dado),
        .car_valido    (car_valido),
        .ocupado       (ocupado),
        .talao_fim     (talao_fim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_dado"},  {24'h0, car_dado}, 32'h0);
        check({tag, "_valid"}, {31'h0, car_valido}, 32'h0);
        check({tag, "_busy"},  {31'h0, ocupado}, 32'h0);
        check({tag, "_fim"},   {31'h0, talao_fim}, 32'h0);
    endtask

    // Presents the request on the edge following the next falling edge;
    // rst is released at the same falling edge so the capture is the first
    // edge after reset deasserts when called straight out of reset.
    task automatic start(input logic [11:0] f, input logic [11:0] p, input logic [4:0] t);
        @(negedge clk);
        rst           = 1'b0;
        soma_final    = f;
        soma_peso     = p;
        valor_taxa    = t;
        emissao_talao = 1'b1;
        @(posedge clk);
        #1;
        emissao_talao = 1'b0;
        check("cap_busy",  {31'h0, ocupado}, 32'h1);
        check("cap_valid", {31'h0, car_valido}, 32'h0);
    endtask

    // Counts edges after the capture edge until car_valido is seen.
    // With disturb set, a second request and new input values are applied
    // during conversion.
    task automatic wait_valid(input bit disturb);
        int n;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (disturb && n == 2) begin
                emissao_talao = 1'b1;
                soma_final    = 12'd999;
                soma_peso     = 12'd1;
                valor_taxa    = 5'd30;
            end
            if (disturb && n == 5)
                emissao_talao = 1'b0;
            if (car_valido)
                break;
        end
        check("latency", n, 12);
    endtask

    // Receives the 14 characters. stall_k/stall_n: hold car_pronto low for
    // stall_n cycles while character stall_k is presented. abort_k: assert
    // rst right after that many transfers. disturb_k: raise a request and
    // change inputs while that character is presented.
    task automatic recv(input int stall_k, input int stall_n, input int abort_k, input int disturb_k);
        for (int k = 0; k < 14; k++) begin
            check($sformatf("char%0d", k), {24'h0, car_dado}, {24'h0, exp_chars[k]});
            check($sformatf("valid%0d", k), {31'h0, car_valido}, 32'h1);
            if (k == stall_k) begin
                car_pronto = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    @(posedge clk);
                    #1;
                    check("stall_dado",  {24'h0, car_dado}, {24'h0, exp_chars[k]});
                    check("stall_valid", {31'h0, car_valido}, 32'h1);
                end
                car_pronto = 1'b1;
            end
            if (k == disturb_k) begin
                emissao_talao = 1'b1;
                soma_final    = 12'd0;
                soma_peso     = 12'd4095;
            end
            @(posedge clk);
            #1;
            emissao_talao = 1'b0;
            if (k + 1 == abort_k) begin
                rst = 1'b1;
                #1;
                check_idle_outputs("abort");
                return;
            end
        end
        check("end_fim",   {31'h0, talao_fim}, 32'h1);
        check("end_valid", {31'h0, car_valido}, 32'h0);
        check("end_dado",  {24'h0, car_dado}, 32'h0);
        check("end_busy",  {31'h0, ocupado}, 32'h1);
        @(posedge clk);
        #1;
        check("post_fim",  {31'h0, talao_fim}, 32'h0);
        check("post_busy", {31'h0, ocupado}, 32'h0);
    endtask

    initial begin
        rst           = 1'b1;
        emissao_talao = 1'b0;
        soma_final    = '0;
        soma_peso     = '0;
        valor_taxa    = '0;
        car_pronto    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");

        // 1000 / 2000 / 5, captured on the first edge after reset release
        exp_chars = '{8'h54, 8'h31, 8'h30, 8'h30, 8'h30, 8'h50, 8'h32,
                      8'h30, 8'h30, 8'h30, 8'h58, 8'h30, 8'h35, 8'h0A};
        start(12'd1000, 12'd2000, 5'd5);
        wait_valid(1'b0);
        recv(-1, 0, -1, -1);

        // Maxima
        exp_chars = '{8'h54, 8'h34, 8'h30, 8'h39, 8'h35, 8'h50, 8'h34,
                      8'h30, 8'h39, 8'h35, 8'h58, 8'h33, 8'h31, 8'h0A};
        start(12'd4095, 12'd4095, 5'd31);
        wait_valid(1'b0);
        recv(-1, 0, -1, -1);

        // All zeros
        exp_chars = '{8'h54, 8'h30, 8'h30, 8'h30, 8'h30, 8'h50, 8'h30,
                      8'h30, 8'h30, 8'h30, 8'h58, 8'h30, 8'h30, 8'h0A};
        start(12'd0, 12'd0, 5'd0);
        wait_valid(1'b0);
        recv(-1, 0, -1, -1);

        // 907 / 56 / 20 with a 3-cycle stall on 'P'
        exp_chars = '{8'h54, 8'h30, 8'h39, 8'h30, 8'h37, 8'h50, 8'h30,
                      8'h30, 8'h35, 8'h36, 8'h58, 8'h32, 8'h30, 8'h0A};
        start(12'd907, 12'd56, 5'd20);
        wait_valid(1'b0);
        recv(5, 3, -1, -1);

        // 123 / 4001 / 9 with requests and input changes during CONV and ENVIA
        exp_chars = '{8'h54, 8'h30, 8'h31, 8'h32, 8'h33, 8'h50, 8'h34,
                      8'h30, 8'h30, 8'h31, 8'h58, 8'h30, 8'h39, 8'h0A};
        start(12'd123, 12'd4001, 5'd9);
        wait_valid(1'b1);
        recv(-1, 0, -1, 3);
        repeat (2) @(posedge clk);
        #1;
        check("no_queue_busy", {31'h0, ocupado}, 32'h0);

        // Abort after the 4th transfer
        exp_chars = '{8'h54, 8'h31, 8'h30, 8'h30, 8'h30, 8'h50, 8'h32,
                      8'h30, 8'h30, 8'h30, 8'h58, 8'h30, 8'h35, 8'h0A};
        start(12'd1000, 12'd2000, 5'd5);
        wait_valid(1'b0);
        recv(-1, 0, 4, -1);
        @(posedge clk);
        #1;
        check_idle_outputs("abort_hold");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abort_idle_busy",  {31'h0, ocupado}, 32'h0);
            check("abort_idle_fim",   {31'h0, talao_fim}, 32'h0);
        end

        // Full receipt after the abort
        exp_chars = '{8'h54, 8'h34, 8'h30, 8'h39, 8'h35, 8'h50, 8'h34,
                      8'h30, 8'h39, 8'h35, 8'h58, 8'h33, 8'h31, 8'h0A};
        start(12'd4095, 12'd4095, 5'd31);
        wait_valid(1'b0);
        recv(-1, 0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
